// File: rtl/sram_link_pkg.sv
// rtl/sram_link_pkg.sv - shared constants, state encoding and helpers for the serial SRAM-address link
package sram_link_pkg;

    // Address width shared with the CPLD address latch.
    localparam int ADDR_W = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } tx_state_e;

    // ceil(log2(v)); 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_addr_tx_tick.sv
// rtl/sram_addr_tx_tick.sv - serial-clock phase down-counter; expire marks the last cycle of a phase
module sram_addr_tx_tick
    import sram_link_pkg::*;
#(
    parameter int CLKDIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int CW = clog2(CLKDIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Depends only on the count register so the FSM can derive load from it without a loop.
    assign expire = (cnt == '0);

endmodule

// File: rtl/sram_addr_tx.sv
// rtl/sram_addr_tx.sv - MSB-first serializer of an SRAM address onto a ser_clk/ser_data pair
module sram_addr_tx
    import sram_link_pkg::*;
#(
    parameter int DWIDTH = ADDR_W,
    parameter int CLKDIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] addr_in,
    input  logic              start,
    input  logic              inc,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] addr_held,
    output logic              ser_clk,
    output logic              ser_data
);

    localparam int BW = (clog2(DWIDTH) < 1) ? 1 : clog2(DWIDTH);
    localparam logic [BW-1:0] MSB_IDX = BW'(DWIDTH - 1);

    tx_state_e         state;
    tx_state_e         state_nx;
    logic [BW-1:0]     bit_idx;
    logic [BW-1:0]     bit_nx;
    logic [DWIDTH-1:0] addr_nx;
    logic              ser_data_nx;
    logic              load;
    logic              expire;

    sram_addr_tx_tick #(
        .CLKDIV (CLKDIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .expire (expire)
    );

    always_comb begin
        state_nx    = state;
        bit_nx      = bit_idx;
        addr_nx     = addr_held;
        ser_data_nx = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    addr_nx  = addr_in;
                    bit_nx   = MSB_IDX;
                    state_nx = LOW;
                end else if (inc) begin
                    addr_nx  = addr_held + DWIDTH'(1);
                    bit_nx   = MSB_IDX;
                    state_nx = LOW;
                end
            end
            LOW: begin
                if (expire) begin
                    state_nx = HIGH;
                end
            end
            HIGH: begin
                if (expire) begin
                    if (bit_idx != '0) begin
                        bit_nx   = bit_idx - BW'(1);
                        state_nx = LOW;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        load = (state_nx != state);

        // Outputs are registered from next-state values, so data only moves on entry to LOW.
        if (state_nx == LOW) begin
            ser_data_nx = addr_nx[bit_nx];
        end else if (state_nx == HIGH) begin
            ser_data_nx = ser_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            addr_held <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ser_clk   <= 1'b0;
            ser_data  <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_idx   <= bit_nx;
            addr_held <= addr_nx;
            busy      <= (state_nx == LOW) || (state_nx == HIGH);
            done      <= (state_nx == DONE);
            ser_clk   <= (state_nx == HIGH);
            ser_data  <= ser_data_nx;
        end
    end

endmodule

// File: tb/tb_sram_addr_tx.sv
// tb/tb_sram_addr_tx.sv - directed vector bench for sram_addr_tx with shift-register receiver model
module tb_sram_addr_tx;
    import sram_link_pkg::*;

    localparam int DW = ADDR_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] addr_in;
    logic          start;
    logic          inc;
    logic          busy;
    logic          done;
    logic [DW-1:0] addr_held;
    logic          ser_clk;
    logic          ser_data;

    logic [DW-1:0] addr_in1;
    logic          start1;
    logic          inc1;
    logic          busy1;
    logic          done1;
    logic [DW-1:0] addr_held1;
    logic          ser_clk1;
    logic          ser_data1;

    logic [DW-1:0] rx  = '0;
    logic [DW-1:0] rx1 = '0;
    int            viol = 0;
    logic          prev_sclk = 1'b0;
    logic          prev_sdata = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_addr_tx #(.DWIDTH(DW), .CLKDIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_in   (addr_in),
        .start     (start),
        .inc       (inc),
        .busy      (busy),
        .done      (done),
        .addr_held (addr_held),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data)
    );

    sram_addr_tx #(.DWIDTH(DW), .CLKDIV(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_in   (addr_in1),
        .start     (start1),
        .inc       (inc1),
        .busy      (busy1),
        .done      (done1),
        .addr_held (addr_held1),
        .ser_clk   (ser_clk1),
        .ser_data  (ser_data1)
    );

    // Reference receiver: the CPLD serial-in shift register.
    always @(posedge ser_clk)  rx  <= {rx[DW-2:0], ser_data};
    always @(posedge ser_clk1) rx1 <= {rx1[DW-2:0], ser_data1};

    always @(negedge clk) begin
        if (prev_sclk && ser_clk && (ser_data != prev_sdata)) viol = viol + 1;
        prev_sclk  = ser_clk;
        prev_sdata = ser_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          s;
        logic          i;
        logic [DW-1:0] a;
        logic [DW-1:0] exp;
        int            intr;
    } vec_t;

    vec_t vecs[8];

    task automatic run_xfer(input string tag, input logic s, input logic i,
                            input logic [DW-1:0] a, input logic [DW-1:0] exp, input int intr);
        int cyc;
        int bcnt;
        int dcyc;
        int dcnt;
        int v0;
        cyc  = 0;
        bcnt = 0;
        dcyc = -1;
        dcnt = 0;
        v0   = viol;
        @(negedge clk);
        start   = s;
        inc     = i;
        addr_in = a;
        while (cyc < 200) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (cyc == 1) begin
                start = 1'b0;
                inc   = 1'b0;
            end
            if (intr != 0 && cyc == intr) begin
                start   = 1'b1;
                inc     = 1'b1;
                addr_in = 21'h055555;
            end
            if (intr != 0 && cyc == intr + 1) begin
                start = 1'b0;
                inc   = 1'b0;
            end
            if (busy) bcnt = bcnt + 1;
            if (done) begin
                dcnt = dcnt + 1;
                if (dcyc < 0) dcyc = cyc;
            end
            if (dcyc >= 0 && cyc >= dcyc + 2) break;
        end
        check({tag, " busy_cycles"}, 64'(bcnt), 64'd84);
        check({tag, " done_cycle"}, 64'(dcyc), 64'd85);
        check({tag, " done_pulses"}, 64'(dcnt), 64'd1);
        check({tag, " rx_value"}, 64'(rx), 64'(exp));
        check({tag, " addr_held"}, 64'(addr_held), 64'(exp));
        check({tag, " data_stable_high"}, 64'(viol - v0), 64'd0);
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcyc;
        int dcnt;
        int tog_err;
        logic prev;

        vecs[0] = '{1'b1, 1'b0, 21'h1ABCDE, 21'h1ABCDE, 0};
        vecs[1] = '{1'b1, 1'b0, 21'h1FFFFF, 21'h1FFFFF, 0};
        vecs[2] = '{1'b0, 1'b1, 21'h0AAAAA, 21'h000000, 0};
        vecs[3] = '{1'b0, 1'b1, 21'h0AAAAA, 21'h000001, 0};
        vecs[4] = '{1'b1, 1'b0, 21'h12A5A5, 21'h12A5A5, 42};
        vecs[5] = '{1'b1, 1'b0, 21'h000005, 21'h000005, 0};
        vecs[6] = '{1'b1, 1'b1, 21'h000100, 21'h000100, 0};
        vecs[7] = '{1'b1, 1'b0, 21'h155554, 21'h155554, 0};

        rst_n    = 1'b0;
        addr_in  = '0;
        start    = 1'b0;
        inc      = 1'b0;
        addr_in1 = '0;
        start1   = 1'b0;
        inc1     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset ser_clk", 64'(ser_clk), 64'd0);
        check("reset ser_data", 64'(ser_data), 64'd0);
        check("reset addr_held", 64'(addr_held), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            run_xfer($sformatf("vec%0d", k), vecs[k].s, vecs[k].i, vecs[k].a, vecs[k].exp, vecs[k].intr);
        end

        // Reset in the high phase of bit 7 of 0x1ABCDE (a '1' bit).
        @(negedge clk);
        start   = 1'b1;
        addr_in = 21'h1ABCDE;
        for (int c = 1; c <= 55; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst ser_clk", 64'(ser_clk), 64'd0);
        check("midrst ser_data", 64'(ser_data), 64'd0);
        check("midrst addr_held", 64'(addr_held), 64'd0);
        check("midrst done", 64'(done), 64'd0);
        dcnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) dcnt = dcnt + 1;
        end
        check("midrst no_done", 64'(dcnt), 64'd0);
        run_xfer("after_reset", 1'b1, 1'b0, 21'h0F0F0F, 21'h0F0F0F, 0);

        // CLKDIV=1 instance: one clk per serial half-period.
        cyc     = 0;
        bcnt    = 0;
        dcyc    = -1;
        dcnt    = 0;
        tog_err = 0;
        prev    = 1'b0;
        @(negedge clk);
        start1   = 1'b1;
        addr_in1 = 21'h000001;
        while (cyc < 100) begin
            @(negedge clk);
            cyc = cyc + 1;
            if (cyc == 1) start1 = 1'b0;
            if (busy1) begin
                bcnt = bcnt + 1;
                if (cyc > 1 && ser_clk1 == prev) tog_err = tog_err + 1;
            end
            prev = ser_clk1;
            if (done1) begin
                dcnt = dcnt + 1;
                if (dcyc < 0) dcyc = cyc;
            end
            if (dcyc >= 0 && cyc >= dcyc + 2) break;
        end
        check("div1 busy_cycles", 64'(bcnt), 64'd42);
        check("div1 done_cycle", 64'(dcyc), 64'd43);
        check("div1 done_pulses", 64'(dcnt), 64'd1);
        check("div1 rx_value", 64'(rx1), 64'h1);
        check("div1 addr_held", 64'(addr_held1), 64'h1);
        check("div1 ser_clk_toggle", 64'(tog_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_addr_tx.md
Name: sram_addr_tx

Overview:
- Transmit end of the serial SRAM-address link.
- Takes a parallel address from the controller side and serializes it MSB-first onto a data/clock pair.
- The pair feeds the CPLD's shift-register address latch, which shifts on every rising edge of the serial clock.
- Adds start/busy/done handshake, clock division and an auto-increment mode for sequential SRAM access.

Parameters:
- DWIDTH, 21, address width in bits; equals the number of serial clock pulses per transfer.
- CLKDIV, 2, clk cycles per serial-clock half-period; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- addr_in  input  DWIDTH  address to send; sampled only when start is accepted.
- start  input  1  load addr_in and transmit; accepted only in IDLE.
- inc  input  1  increment held address by 1 and transmit; accepted only in IDLE.
- busy  output  1  high from the cycle after acceptance through the last high phase.
- done  output  1  one-cycle pulse when a transfer completes.
- addr_held  output  DWIDTH  address currently held / last sent.
- ser_clk  output  1  serial clock to the shift register.
- ser_data  output  1  serial data; changes only while ser_clk is low.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, ser_clk=0, ser_data=0, addr_held=0, counters=0. Reset overrides everything, including mid-transfer; no completion pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states:
  - IDLE: ser_clk=0. start=1 -> addr_held<=addr_in, go LOW. Else inc=1 -> addr_held<=addr_held+1 (mod 2^DWIDTH, 0x1FFFFF wraps to 0x000000), go LOW. start has priority when both are high.
  - LOW: ser_clk=0, ser_data=addr_held[bit_idx]. Lasts CLKDIV cycles, then go HIGH.
  - HIGH: ser_clk=1, ser_data held. Lasts CLKDIV cycles. If bit_idx>0, decrement bit_idx and go LOW. If bit_idx==0, go DONE.
  - DONE: one cycle; done=1, busy=0, ser_clk=0, ser_data=0; then IDLE.
- Bit order: bit_idx starts at DWIDTH-1 (MSB first), so the receiver's buffer ends holding addr_held exactly.
- Cycle timing:
  - Acceptance edge is T0; busy=1 and ser_clk=0 from T0+1.
  - Busy lasts exactly DWIDTH*2*CLKDIV cycles (84 with defaults).
  - done is high at T0+1+DWIDTH*2*CLKDIV.
  - Next start is accepted at the earliest one cycle after done; the fastest repeat is every DWIDTH*2*CLKDIV+2 cycles.
- Setup and hold at the receiver: ser_data is stable for CLKDIV cycles before and CLKDIV cycles after each ser_clk rise.
- start or inc while busy or in DONE is ignored: not queued, no effect on addr_held.
- addr_in changing during a transfer has no effect.
- Reset mid-transfer leaves the receiver holding a partial shift; the controller must resend after reset.
- Phase counter: width ceil(log2(CLKDIV+1)); it reloads on every state change. CLKDIV=1 gives ser_clk = clk/2.

Decomposition:
- Shared package sram_link_pkg:
  - ADDR_W=21 constant, shared with the CPLD address latch.
  - State enum {IDLE, LOW, HIGH, DONE}.
  - Function clog2.
- One sub-module, sram_addr_tx_tick: CLKDIV phase down-counter with a load input and a one-cycle expire pulse; the FSM advances on expire.
- Bench model: the existing serial-in shift register, driven with clk=ser_clk and in=ser_data, serves as the reference receiver.

Test Plan:
- Basic send: defaults, addr_in=0x1ABCDE, start for 1 cycle -> busy high exactly 84 cycles, done pulses once, receiver model holds 0x1ABCDE, ser_data never changes while ser_clk=1.
- Auto-increment with wrap: send 0x1FFFFF, then inc pulse after done -> addr_held=0x000000, receiver holds 0x000000. A further inc gives 0x000001.
- Ignored requests: start with 0x055555 while busy, in the middle of bit 10 -> no effect; the first transfer completes unchanged; a single done pulse.
- Priority: start=1 and inc=1 in the same IDLE cycle with addr_in=0x000100, addr_held=0x000005 -> 0x000100 is sent, not 0x000006.
- Reset mid-transfer: rst_n=0 for 1 cycle at bit 7 -> next cycle busy=0, ser_clk=0, ser_data=0, addr_held=0, no done. A fresh start of 0x0F0F0F then completes correctly.
- CLKDIV=1: send 0x000001 -> 42 busy cycles, ser_clk toggles every cycle, receiver holds 0x000001, done at T0+43.
